picosoc_bus_decoder: RTL and testbench

- Parametrised successor to the SoC's hard-wired address decode/ready/rdata mux.
- Routes one PicoRV32-style native memory master to NSLAVES address-windowed slaves, with one outstanding transaction.
- Adds registered slave select and a registered response path.
- Adds decode-error and timeout-error responses, an error IRQ pulse and error address capture.

---
 rtl/picosoc_bus_pkg.sv | 19 +
 rtl/picosoc_addr_match.sv | 30 +++
 rtl/picosoc_bus_decoder.sv | 179 +++++++++++++++++
 tb/tb_picosoc_bus_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoSoC native-bus decoder.
//   state_t    : decoder FSM state encoding (IDLE/ACTIVE/RESP)
//   ERR_*      : cause of the response currently being produced
//   ERR_CNT_W  : width of the saturating error counter
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/picosoc_addr_match.sv
// Combinational priority address decoder.
//   addr_i : address to decode
//   base_i : packed NSLAVES*32 window bases, slave i at [32*i+:32]
//   mask_i : packed NSLAVES*32 window masks, slave i at [32*i+:32]
//   hit_o  : at least one window matches
//   idx_o  : lowest matching slave index (0 when no hit)
module picosoc_addr_match #(
  parameter int NSLAVES = 4,
  parameter int IDX_W   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
  input  logic [31:0]           addr_i,
  input  logic [NSLAVES*32-1:0] base_i,
  input  logic [NSLAVES*32-1:0] mask_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((addr_i & mask_i[32*i +: 32]) == base_i[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_decoder.sv
// Routes one PicoRV32 native memory master to NSLAVES address-windowed
// slaves, one transaction outstanding, with decode/timeout error responses.
//   clk, reset                     : clock, async active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb : master request (wstrb == 0 is a read)
//   m_ready/m_rdata/m_err          : registered one-cycle response
//   s_valid (one-hot), s_addr/s_wdata/s_wstrb (broadcast) : slave request
//   s_ready, s_rdata (packed)      : per-slave response
//   err_irq/err_addr/err_count     : error pulse, last error address, count
//
// state  | meaning
// IDLE   | waiting for m_valid; decode and register the request
// ACTIVE | s_valid to selected slave; wait for s_ready or timeout
// RESP   | m_ready high for one cycle, then back to IDLE
module picosoc_bus_decoder
  import picosoc_bus_pkg::*;
#(
  parameter int                    NSLAVES        = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE     = {NSLAVES{32'h0}},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK     = {NSLAVES{32'hFF00_0000}},
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_valid,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [3:0]            m_wstrb,
  output logic                  m_ready,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic [NSLAVES-1:0]    s_valid,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [NSLAVES-1:0]    s_ready,
  input  logic [NSLAVES*32-1:0] s_rdata,
  output logic                  err_irq,
  output logic [31:0]           err_addr,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                 state_q;
  logic [IDX_W-1:0]       sel_q;
  logic [NSLAVES-1:0]     s_valid_q;
  logic [31:0]            s_addr_q;
  logic [31:0]            s_wdata_q;
  logic [3:0]             s_wstrb_q;
  logic                   m_ready_q;
  logic                   m_err_q;
  logic [31:0]            m_rdata_q;
  logic                   err_irq_q;
  logic [31:0]            err_addr_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic [TO_W-1:0]        to_cnt_q;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;
  logic [1:0]             err_cause;

  picosoc_addr_match #(
    .NSLAVES (NSLAVES),
    .IDX_W   (IDX_W)
  ) u_addr_match (
    .addr_i (m_addr),
    .base_i (SLAVE_BASE),
    .mask_i (SLAVE_MASK),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[32*sel_q +: 32];

  // s_ready on the last timeout cycle wins over the timeout.
  always_comb begin
    err_cause = ERR_NONE;
    case (state_q)
      IDLE:    if (m_valid && !dec_hit) err_cause = ERR_DECODE;
      ACTIVE:  if (m_valid && !sel_ready && TO_EN && (to_cnt_q == TO_LAST))
                 err_cause = ERR_TIMEOUT;
      default: err_cause = ERR_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      s_valid_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      m_ready_q   <= 1'b0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      m_ready_q <= 1'b0;
      err_irq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (m_valid) begin
            s_addr_q  <= m_addr;
            s_wdata_q <= m_wdata;
            s_wstrb_q <= m_wstrb;
            sel_q     <= dec_idx;
            if (dec_hit) begin
              s_valid_q <= NSLAVES'(1) << dec_idx;
              state_q   <= ACTIVE;
            end else begin
              state_q   <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!m_valid) begin
            // master gave up: silent abort, no response
            s_valid_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= IDLE;
          end else if (sel_ready) begin
            s_valid_q <= '0;
            m_rdata_q <= sel_rdata;
            m_err_q   <= 1'b0;
            m_ready_q <= 1'b1;
            state_q   <= RESP;
          end else if (err_cause == ERR_TIMEOUT) begin
            s_valid_q <= '0;
            state_q   <= RESP;
          end else begin
            to_cnt_q  <= to_cnt_q + 1'b1;
          end
        end
        RESP: begin
          m_err_q  <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (err_cause != ERR_NONE) begin
        m_ready_q  <= 1'b1;
        m_err_q    <= 1'b1;
        m_rdata_q  <= ERR_RDATA;
        err_irq_q  <= 1'b1;
        // on a decode error s_addr is being loaded this same edge
        err_addr_q <= (err_cause == ERR_DECODE) ? m_addr : s_addr_q;
        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign m_ready   = m_ready_q;
  assign m_rdata   = m_rdata_q;
  assign m_err     = m_err_q;
  assign s_valid   = s_valid_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_picosoc_bus_decoder.sv
// Directed bench for picosoc_bus_decoder: 4 slaves, 8-cycle timeout.
module tb_picosoc_bus_decoder;

  localparam int NS = 4;
  // slave 0: 0x0000_0xxx, slave 1: 0x02xx_xxxx,
  // slave 2: addr & FFFF_0F00 == 0x100 (overlaps slave 0 at 0x100),
  // slave 3: 0x04xx_xxxx
  localparam logic [NS*32-1:0] BASE =
    {32'h0400_0000, 32'h0000_0100, 32'h0200_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK =
    {32'hFF00_0000, 32'hFFFF_0F00, 32'hFF00_0000, 32'hFFFF_F000};

  logic              clk;
  logic              reset;
  logic              m_valid;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_ready;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_valid;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS-1:0]     s_ready;
  logic [NS*32-1:0]  s_rdata;
  logic              err_irq;
  logic [31:0]       err_addr;
  logic [7:0]        err_count;

  picosoc_bus_decoder #(
    .NSLAVES        (NS),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_irq   (err_irq),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // captured at the response cycle by run_xfer
  int          r_lat;
  int          r_sv_cnt;
  logic [3:0]  r_sv_or;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_irq;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for m_ready. r_lat is the edge,
  // counting the m_valid sampling edge as 1, at which the master sees m_ready;
  // 0 means no response arrived. If rdy_after > 0, s_ready is set to rdy_val
  // right after that edge.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rdy_after,
                          input logic [3:0] rdy_val);
    m_valid  = 1'b1;
    m_addr   = addr;
    m_wdata  = wdata;
    m_wstrb  = wstrb;
    r_lat    = 0;
    r_sv_cnt = 0;
    r_sv_or  = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      r_sv_or = r_sv_or | s_valid;
      if (s_valid != '0) r_sv_cnt++;
      if (m_ready) begin
        r_lat = i + 1;
        break;
      end
      if (i == rdy_after) s_ready = rdy_val;
    end
    r_rdata = m_rdata;
    r_err   = m_err;
    r_irq   = err_irq;
    m_valid = 1'b0;
  endtask

  initial begin
    logic any_resp;
    int   bad_lat;

    reset   = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hAAAA_0000};
    tick();
    tick();
    check_val("rst_s_valid",   {28'h0, s_valid}, 32'h0);
    check_val("rst_m_ready",   {31'h0, m_ready}, 32'h0);
    check_val("rst_m_err",     {31'h0, m_err}, 32'h0);
    check_val("rst_err_irq",   {31'h0, err_irq}, 32'h0);
    check_val("rst_m_rdata",   m_rdata, 32'h0);
    check_val("rst_s_addr",    s_addr, 32'h0);
    check_val("rst_err_addr",  err_addr, 32'h0);
    check_val("rst_err_count", {24'h0, err_count}, 32'h0);
    reset = 1'b0;
    tick();

    // read hit on slave 1, ready in the first ACTIVE cycle
    s_ready = 4'b0010;
    run_xfer(32'h0200_0000, 32'h0, 4'b0000, 0, 4'b0000);
    check_val("rd1_lat",     r_lat, 3);
    check_val("rd1_rdata",   r_rdata, 32'h1234_5678);
    check_val("rd1_err",     {31'h0, r_err}, 32'h0);
    check_val("rd1_irq",     {31'h0, r_irq}, 32'h0);
    check_val("rd1_sv_or",   {28'h0, r_sv_or}, 32'h2);
    check_val("rd1_sv_cnt",  r_sv_cnt, 1);
    check_val("rd1_errcnt",  {24'h0, err_count}, 32'h0);
    tick();
    check_val("rd1_ready_1cyc", {31'h0, m_ready}, 32'h0);

    // write with no matching window -> decode error
    s_ready = 4'b0000;
    run_xfer(32'h0300_0010, 32'h5555_AAAA, 4'b0011, 0, 4'b0000);
    check_val("dec_lat",     r_lat, 2);
    check_val("dec_err",     {31'h0, r_err}, 32'h1);
    check_val("dec_rdata",   r_rdata, 32'hFFFF_FFFF);
    check_val("dec_irq",     {31'h0, r_irq}, 32'h1);
    check_val("dec_sv_or",   {28'h0, r_sv_or}, 32'h0);
    check_val("dec_err_addr", err_addr, 32'h0300_0010);
    check_val("dec_errcnt",  {24'h0, err_count}, 32'h1);
    check_val("dec_s_wstrb", {28'h0, s_wstrb}, 32'h3);
    tick();
    check_val("dec_irq_1cyc", {31'h0, err_irq}, 32'h0);
    check_val("dec_err_1cyc", {31'h0, m_err}, 32'h0);

    // slave 3 never ready -> timeout after 8 ACTIVE cycles
    run_xfer(32'h0400_0000, 32'h0, 4'b0000, 0, 4'b0000);
    check_val("to_lat",      r_lat, 10);
    check_val("to_sv_cnt",   r_sv_cnt, 8);
    check_val("to_sv_or",    {28'h0, r_sv_or}, 32'h8);
    check_val("to_err",      {31'h0, r_err}, 32'h1);
    check_val("to_rdata",    r_rdata, 32'hFFFF_FFFF);
    check_val("to_irq",      {31'h0, r_irq}, 32'h1);
    check_val("to_err_addr", err_addr, 32'h0400_0000);
    check_val("to_errcnt",   {24'h0, err_count}, 32'h2);
    tick();

    // ready arrives in the final timeout cycle -> normal response
    s_ready = 4'b0000;
    run_xfer(32'h0400_0000, 32'h0, 4'b0000, 8, 4'b1000);
    check_val("tolast_lat",    r_lat, 10);
    check_val("tolast_sv_cnt", r_sv_cnt, 8);
    check_val("tolast_err",    {31'h0, r_err}, 32'h0);
    check_val("tolast_rdata",  r_rdata, 32'h3333_3333);
    check_val("tolast_irq",    {31'h0, r_irq}, 32'h0);
    check_val("tolast_errcnt", {24'h0, err_count}, 32'h2);
    s_ready = 4'b0000;
    tick();

    // overlapping windows 0 and 2 at 0x100 -> slave 0
    s_ready = 4'b0101;
    run_xfer(32'h0000_0100, 32'h0, 4'b0000, 0, 4'b0000);
    check_val("ovl_lat",   r_lat, 3);
    check_val("ovl_sv_or", {28'h0, r_sv_or}, 32'h1);
    check_val("ovl_rdata", r_rdata, 32'hAAAA_0000);
    check_val("ovl_err",   {31'h0, r_err}, 32'h0);
    tick();

    // write to slave 2 only
    s_ready = 4'b0100;
    run_xfer(32'h0000_1104, 32'hDEAD_BEEF, 4'b1111, 0, 4'b0000);
    check_val("wr2_lat",     r_lat, 3);
    check_val("wr2_sv_or",   {28'h0, r_sv_or}, 32'h4);
    check_val("wr2_rdata",   r_rdata, 32'h2222_2222);
    check_val("wr2_s_addr",  s_addr, 32'h0000_1104);
    check_val("wr2_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check_val("wr2_s_wstrb", {28'h0, s_wstrb}, 32'hF);
    tick();

    // reset asserted mid-ACTIVE
    s_ready = 4'b0000;
    m_valid = 1'b1;
    m_addr  = 32'h0400_0000;
    m_wstrb = 4'b0000;
    tick();
    check_val("rstact_sv_before", {28'h0, s_valid}, 32'h8);
    #2 reset = 1'b1;
    #1;
    check_val("rstact_sv_async", {28'h0, s_valid}, 32'h0);
    check_val("rstact_errcnt",   {24'h0, err_count}, 32'h0);
    m_valid = 1'b0;
    tick();
    reset = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_resp = any_resp | m_ready | err_irq | (|s_valid);
    end
    check_val("rstact_no_resp", {31'h0, any_resp}, 32'h0);

    // master drops m_valid mid-ACTIVE -> silent abort
    m_valid = 1'b1;
    m_addr  = 32'h0400_0000;
    tick();
    check_val("abort_sv_before", {28'h0, s_valid}, 32'h8);
    m_valid = 1'b0;
    tick();
    check_val("abort_sv_next", {28'h0, s_valid}, 32'h0);
    any_resp = m_ready | err_irq;
    for (int i = 0; i < 12; i++) begin
      tick();
      any_resp = any_resp | m_ready | err_irq | (|s_valid);
    end
    check_val("abort_no_resp", {31'h0, any_resp}, 32'h0);
    check_val("abort_errcnt",  {24'h0, err_count}, 32'h0);

    // decoder still works after the abort
    s_ready = 4'b0010;
    run_xfer(32'h0200_0040, 32'h0, 4'b0000, 0, 4'b0000);
    check_val("post_abort_lat",   r_lat, 3);
    check_val("post_abort_rdata", r_rdata, 32'h1234_5678);
    tick();

    // 300 decode errors -> counter saturates
    s_ready = 4'b0000;
    bad_lat = 0;
    for (int k = 0; k < 300; k++) begin
      run_xfer(32'h0500_0000 + 32'(k), 32'h0, 4'b0000, 0, 4'b0000);
      if (r_lat != 2 || r_err !== 1'b1) bad_lat++;
      tick();
    end
    check_val("sat_bad_resp", bad_lat, 0);
    check_val("sat_errcnt",   {24'h0, err_count}, 32'hFF);
    check_val("sat_err_addr", err_addr, 32'h0500_012B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
